ir_cmd_decoder: RTL and testbench
=================================

IR_CMD_DECODER -- requirements
Module: ir_cmd_decoder

Interface
REQ-001 Parameter CUSTOM_CODE, default 16'h6B86: remote address accepted in ir_data[15:0].
REQ-002 Parameter HOLD_CYCLES, default 6_500_000 (130 ms at 50 MHz): key-hold timeout after the last valid frame.
REQ-003 clk  in  1  system clock, 50 MHz; one clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 data_ready  in  1  frame-available level from the IR receiver; asynchronous to nothing, already in the clk domain.
REQ-006 ir_data  in  32  decoded NEC frame: [31:24] inverted key, [23:16] key, [15:0] custom code.
REQ-007 cmd_key  out  8  key code of the pending event.
REQ-008 cmd_press  out  1  1 = press event, 0 = release event.
REQ-009 cmd_valid  out  1  event pending (valid/ready handshake).
REQ-010 cmd_ready  in  1  consumer accepts the event when high with cmd_valid.
REQ-011 key_active  out  1  a key is currently held (state HOLD).
REQ-012 held_key  out  8  key currently held; last held key while idle.
REQ-013 err_count  out  8  count of rejected frames, saturating.
REQ-014 overflow  out  1  sticky; an unconsumed event was overwritten.

Function
REQ-015 Frame detection: registered rising edge of data_ready only; a level held high SHALL yield exactly one frame.
REQ-016 On the detected edge (cycle N), ir_data SHALL be captured; validation occurs in cycle N+1.
REQ-017 Valid frame: ir_data[31:24] == ~ir_data[23:16] AND ir_data[15:0] == CUSTOM_CODE.
REQ-018 Invalid frame: err_count += 1, saturating at 8'hFF; no event; state and hold timer unchanged.
REQ-019 States: IDLE, CHECK, HOLD; CHECK returns to the state it came from unless a valid frame is accepted.
REQ-020 IDLE + valid frame: queue press event {key, press=1}, held_key = key, hold timer loaded, go to HOLD.
REQ-021 HOLD + valid frame with key == held_key: repeat; reload the hold timer only; no event.
REQ-022 HOLD + valid frame with a different key: queue release of the old key, then press of the new key, through the same slot in that order; the release is dropped per REQ-026 if not consumed. held_key = new key; timer reloaded.
REQ-023 Hold timer: down-counter, width clog2(HOLD_CYCLES)+1. Expiry exactly HOLD_CYCLES cycles after the last accepting CHECK cycle queues release {held_key, press=0} and enters IDLE.
REQ-024 Latency: cmd_valid rises in cycle N+2 for a press from the data_ready edge in cycle N; a release rises in the cycle after expiry.
REQ-025 Handshake: cmd_valid, cmd_key and cmd_press SHALL be stable while cmd_valid && !cmd_ready; the event is cleared on the cycle cmd_valid && cmd_ready.
REQ-026 Single-entry slot: a new event while cmd_valid && !cmd_ready overwrites the slot and sets overflow.
REQ-027 A new event in the same cycle as cmd_valid && cmd_ready loads the slot; overflow is unchanged.
REQ-028 A new data_ready edge arriving during CHECK SHALL be captured and processed in the following cycle; it is not lost.
REQ-029 Timer expiry in the same cycle as a valid repeat frame: the repeat wins; no release is emitted.
REQ-030 key_active = 1 iff state is HOLD or the CHECK entered from HOLD.

Reset
REQ-031 rst high SHALL asynchronously force: state IDLE, cmd_valid 0, cmd_key 0, cmd_press 0, key_active 0, held_key 0, err_count 0, overflow 0, timer 0, edge register 0.
REQ-032 Reset mid-hold or with an event pending SHALL discard it; no release is emitted after reset.
REQ-033 Only a data_ready edge occurring after rst deasserts SHALL be processed.

Verification (HOLD_CYCLES=100 in bench)
REQ-034 ir_data=32'hE51A6B86 with a data_ready edge, cmd_ready=1 -> cmd_valid at N+2, cmd_key=8'h1A, cmd_press=1, key_active=1; 100 cycles later, release with cmd_key=8'h1A, cmd_press=0.
REQ-035 The same frame repeated every 60 cycles, 5 times -> exactly one press event; release 100 cycles after the 5th frame.
REQ-036 ir_data=32'hE41A6B86 (bad inverse), then 32'hE51A1234 (bad address) -> no events; err_count=2; 300 bad frames -> err_count=8'hFF.
REQ-037 cmd_ready=0; frame key 8'h1A, then after release, frame key 8'h05 -> slot shows the latest event, overflow=1; cmd_ready=1 clears cmd_valid in one cycle.
REQ-038 rst pulse 3 cycles while in HOLD with cmd_valid=1 -> all outputs at reset values; no release emitted in the next 200 cycles.

Source files
------------

// File: rtl/ir_cmd_decoder_if.sv
// Bundles the IR receiver frame input and the key-event valid/ready handshake
// plus the decoder's status outputs.
interface ir_cmd_decoder_if;
    logic        data_ready;
    logic [31:0] ir_data;
    logic [7:0]  cmd_key;
    logic        cmd_press;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        key_active;
    logic [7:0]  held_key;
    logic [7:0]  err_count;
    logic        overflow;

    // master is the decoder; slave is the receiver plus event consumer side.
    modport master (
        input  data_ready, ir_data, cmd_ready,
        output cmd_key, cmd_press, cmd_valid, key_active, held_key, err_count, overflow
    );
    modport slave (
        output data_ready, ir_data, cmd_ready,
        input  cmd_key, cmd_press, cmd_valid, key_active, held_key, err_count, overflow
    );
endinterface

// File: rtl/ir_cmd_decoder.sv
// NEC remote command decoder: validates frames, tracks the held key with a
// hold timer and emits press/release events through a single-entry slot.
module ir_cmd_decoder #(
    parameter logic [15:0] CUSTOM_CODE = 16'h6B86,
    parameter int unsigned HOLD_CYCLES = 6_500_000
) (
    input  logic             clk,
    input  logic             rst,
    ir_cmd_decoder_if.master bus
);
    localparam int unsigned   TW        = $clog2(HOLD_CYCLES) + 1;
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          from_hold_q, from_hold_d;
    logic          dr_q, dr_d;
    logic [31:0]   frame_q, frame_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    held_key_q, held_key_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          pend_press_q, pend_press_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic [7:0]    cmd_key_q, cmd_key_d;
    logic          cmd_press_q, cmd_press_d;
    logic          overflow_q, overflow_d;

    logic          edge_det;
    logic          frame_ok;
    logic [7:0]    frame_key;
    logic          expire;
    logic          stay_hold;
    logic          ev_valid;
    logic [7:0]    ev_key;
    logic          ev_press;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path infers a latch.
        dr_d         = bus.data_ready;
        edge_det     = bus.data_ready & ~dr_q;
        frame_d      = edge_det ? bus.ir_data : frame_q;
        frame_key    = frame_q[23:16];
        frame_ok     = (frame_q[31:24] == ~frame_q[23:16]) && (frame_q[15:0] == CUSTOM_CODE);
        expire       = (timer_q == TW'(1));
        timer_d      = (timer_q != '0) ? timer_q - TW'(1) : timer_q;
        held_key_d   = held_key_q;
        err_count_d  = err_count_q;
        pend_press_d = 1'b0;
        stay_hold    = 1'b0;
        // The second half of a key change: press of the new (already held) key.
        ev_valid     = pend_press_q;
        ev_key       = held_key_q;
        ev_press     = 1'b1;

        case (state_q)
            HOLD: begin
                stay_hold = ~expire;
                if (expire) begin
                    ev_valid = 1'b1;
                    ev_key   = held_key_q;
                    ev_press = 1'b0;
                end
            end
            CHECK: begin
                if (frame_ok) begin
                    // An accepted frame reloads the timer, so a same-cycle expiry is ignored.
                    stay_hold  = 1'b1;
                    timer_d    = HOLD_LOAD;
                    held_key_d = frame_key;
                    if (!from_hold_q) begin
                        ev_valid = 1'b1;
                        ev_key   = frame_key;
                        ev_press = 1'b1;
                    end else if (frame_key != held_key_q) begin
                        ev_valid     = 1'b1;
                        ev_key       = held_key_q;
                        ev_press     = 1'b0;
                        pend_press_d = 1'b1;
                    end
                end else begin
                    stay_hold = from_hold_q & ~expire;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                    if (from_hold_q && expire) begin
                        ev_valid = 1'b1;
                        ev_key   = held_key_q;
                        ev_press = 1'b0;
                    end
                end
            end
            default: stay_hold = 1'b0;
        endcase

        state_d     = edge_det ? CHECK : (stay_hold ? HOLD : IDLE);
        from_hold_d = stay_hold;

        cmd_valid_d = cmd_valid_q;
        cmd_key_d   = cmd_key_q;
        cmd_press_d = cmd_press_q;
        overflow_d  = overflow_q;
        if (ev_valid) begin
            cmd_valid_d = 1'b1;
            cmd_key_d   = ev_key;
            cmd_press_d = ev_press;
            if (cmd_valid_q && !bus.cmd_ready) begin
                overflow_d = 1'b1;
            end
        end else if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            from_hold_q  <= 1'b0;
            dr_q         <= 1'b0;
            frame_q      <= '0;
            timer_q      <= '0;
            held_key_q   <= '0;
            err_count_q  <= '0;
            pend_press_q <= 1'b0;
            cmd_valid_q  <= 1'b0;
            cmd_key_q    <= '0;
            cmd_press_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            from_hold_q  <= from_hold_d;
            dr_q         <= dr_d;
            frame_q      <= frame_d;
            timer_q      <= timer_d;
            held_key_q   <= held_key_d;
            err_count_q  <= err_count_d;
            pend_press_q <= pend_press_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_key_q    <= cmd_key_d;
            cmd_press_q  <= cmd_press_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.cmd_key    = cmd_key_q;
    assign bus.cmd_press  = cmd_press_q;
    assign bus.key_active = (state_q == HOLD) || ((state_q == CHECK) && from_hold_q);
    assign bus.held_key   = held_key_q;
    assign bus.err_count  = err_count_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Randomized and directed bench for ir_cmd_decoder with a frame-level
// reference model of press/release timing.
module tb_ir_cmd_decoder;
    localparam int unsigned HOLD = 100;
    localparam logic [15:0] CODE = 16'h6B86;

    typedef struct packed {
        logic [31:0] at;
        logic [7:0]  key;
        logic        press;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    ir_cmd_decoder_if bus ();

    ir_cmd_decoder #(.CUSTOM_CODE(CODE), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    // Every handshake the consumer completes, stamped with its cycle.
    always @(negedge clk)
        if (!rst && bus.cmd_valid && bus.cmd_ready)
            obs_q.push_back('{at: cyc, key: bus.cmd_key, press: bus.cmd_press});

    // Reference model state: frame-level view of the held key and its deadline.
    bit          m_hold;
    logic [7:0]  m_key;
    int unsigned m_exp;
    logic [7:0]  m_err;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // NOTE: inputs change 1 time unit after the rising edge, never on it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned k);
        repeat (k) tick();
    endtask

    function automatic logic [31:0] good_frame(input logic [7:0] k);
        return {~k, k, CODE};
    endfunction

    function automatic logic [31:0] bad_frame();
        logic [31:0] d;
        d = $urandom();
        if (d[31:24] == ~d[23:16] && d[15:0] == CODE) d[0] = ~d[0];
        return d;
    endfunction

    // Raises data_ready with d at cycle n, holds the level len cycles, scrambles ir_data after the edge.
    task automatic send_frame(input logic [31:0] d, input int unsigned len, output int unsigned n);
        bus.ir_data    = d;
        bus.data_ready = 1'b1;
        n = cyc;
        tick();
        bus.ir_data = $urandom();
        repeat (len - 1) tick();
        bus.data_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.data_ready = 1'b0;
        idle(2);
        rst = 1'b0;
        idle(2);
    endtask

    // Frame with rising edge at cycle n; decision cycle is n+1, events appear the cycle after they are queued.
    task automatic model_frame(input int unsigned n, input logic [31:0] d);
        int unsigned c;
        bit ok;
        c  = n + 1;
        ok = (d[31:24] == ~d[23:16]) && (d[15:0] == CODE);
        if (m_hold && (m_exp < c || (m_exp == c && !ok))) begin
            exp_q.push_back('{at: m_exp + 1, key: m_key, press: 1'b0});
            m_hold = 0;
        end
        if (ok) begin
            if (!m_hold) begin
                exp_q.push_back('{at: c + 1, key: d[23:16], press: 1'b1});
            end else if (d[23:16] != m_key) begin
                exp_q.push_back('{at: c + 1, key: m_key, press: 1'b0});
                exp_q.push_back('{at: c + 2, key: d[23:16], press: 1'b1});
            end
            m_hold = 1;
            m_key  = d[23:16];
            m_exp  = c + HOLD;
        end else if (m_err != 8'hFF) begin
            m_err = m_err + 8'd1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(3);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.key_active, bus.held_key, bus.err_count, bus.overflow} !== 28'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%b key=%h press=%b active=%b held=%h err=%h ovf=%b, want all zero",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.key_active, bus.held_key, bus.err_count, bus.overflow);
        end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_single_press();
        int unsigned n;
        exp_q.delete();
        obs_q.delete();
        bus.cmd_ready = 1'b1;
        send_frame(32'hE51A6B86, 1, n);
        tick();
        n_cmp++;
        if (bus.key_active !== 1'b1) begin
            n_bad++;
            $display("FAIL single_key_active: got %b, want 1", bus.key_active);
        end
        idle(110);
        exp_q.push_back('{at: n + 2, key: 8'h1A, press: 1'b1});
        exp_q.push_back('{at: n + 2 + HOLD, key: 8'h1A, press: 1'b0});
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL single_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL single_ev%0d: got cyc=%0d key=%h press=%b, want cyc=%0d key=%h press=%b",
                         i, obs_q[i].at, obs_q[i].key, obs_q[i].press, exp_q[i].at, exp_q[i].key, exp_q[i].press);
            end
        end
        n_cmp++;
        if (bus.key_active !== 1'b0) begin
            n_bad++;
            $display("FAIL single_released: key_active got %b, want 0", bus.key_active);
        end
    endtask

    task automatic test_repeat();
        int unsigned n, n0, len;
        exp_q.delete();
        obs_q.delete();
        bus.cmd_ready = 1'b1;
        n0 = 0;
        for (int i = 0; i < 5; i++) begin
            len = $urandom_range(1, 4);
            send_frame(32'hE51A6B86, len, n);
            if (i == 0) n0 = n;
            idle(60 - len);
        end
        idle(120);
        exp_q.push_back('{at: n0 + 2, key: 8'h1A, press: 1'b1});
        exp_q.push_back('{at: n + 2 + HOLD, key: 8'h1A, press: 1'b0});
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL repeat_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL repeat_ev%0d: got cyc=%0d key=%h press=%b, want cyc=%0d key=%h press=%b",
                         i, obs_q[i].at, obs_q[i].key, obs_q[i].press, exp_q[i].at, exp_q[i].key, exp_q[i].press);
            end
        end
    endtask

    task automatic test_key_change();
        int unsigned n0, n1;
        exp_q.delete();
        obs_q.delete();
        bus.cmd_ready = 1'b1;
        send_frame(good_frame(8'h1A), 2, n0);
        idle(28);
        send_frame(good_frame(8'h05), 3, n1);
        idle(115);
        exp_q.push_back('{at: n0 + 2, key: 8'h1A, press: 1'b1});
        exp_q.push_back('{at: n1 + 2, key: 8'h1A, press: 1'b0});
        exp_q.push_back('{at: n1 + 3, key: 8'h05, press: 1'b1});
        exp_q.push_back('{at: n1 + 2 + HOLD, key: 8'h05, press: 1'b0});
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL change_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL change_ev%0d: got cyc=%0d key=%h press=%b, want cyc=%0d key=%h press=%b",
                         i, obs_q[i].at, obs_q[i].key, obs_q[i].press, exp_q[i].at, exp_q[i].key, exp_q[i].press);
            end
        end
        n_cmp++;
        if (bus.held_key !== 8'h05) begin
            n_bad++;
            $display("FAIL change_held_idle: held_key got %h, want 05", bus.held_key);
        end
    endtask

    task automatic test_random();
        int unsigned n, gap, len, sel;
        logic [31:0] d;
        logic [7:0]  keys [4];
        keys = '{8'h1A, 8'h05, 8'h33, 8'hC8};
        do_reset();
        exp_q.delete();
        obs_q.delete();
        m_hold = 0;
        m_key  = 8'h00;
        m_exp  = 0;
        m_err  = 8'h00;
        bus.cmd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            sel = $urandom_range(0, 9);
            d   = (sel < 7) ? good_frame(keys[2'($urandom_range(0, 3))]) : bad_frame();
            sel = $urandom_range(0, 9);
            if (sel < 4)       gap = $urandom_range(2, 10);
            else if (sel < 7)  gap = $urandom_range(40, 99);
            else if (sel == 7) gap = HOLD;
            else               gap = $urandom_range(101, 140);
            len = $urandom_range(1, gap - 1);
            send_frame(d, len, n);
            model_frame(n, d);
            idle(gap - len);
        end
        idle(150);
        if (m_hold) exp_q.push_back('{at: m_exp + 1, key: m_key, press: 1'b0});
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL random_count: got %0d events, want %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL random_ev%0d: got cyc=%0d key=%h press=%b, want cyc=%0d key=%h press=%b",
                         i, obs_q[i].at, obs_q[i].key, obs_q[i].press, exp_q[i].at, exp_q[i].key, exp_q[i].press);
            end
        end
        n_cmp++;
        if (bus.err_count !== m_err) begin
            n_bad++;
            $display("FAIL random_err_count: got %h, want %h", bus.err_count, m_err);
        end
        n_cmp++;
        if (bus.held_key !== m_key) begin
            n_bad++;
            $display("FAIL random_held_key: got %h, want %h", bus.held_key, m_key);
        end
    endtask

    task automatic test_errors();
        int unsigned n;
        do_reset();
        obs_q.delete();
        bus.cmd_ready = 1'b1;
        send_frame(32'hE41A6B86, 1, n);
        idle(5);
        send_frame(32'hE51A1234, 2, n);
        idle(5);
        n_cmp++;
        if (bus.err_count !== 8'd2 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL errors_two: err_count=%h events=%0d, want 02 and 0", bus.err_count, obs_q.size());
        end
        for (int i = 0; i < 300; i++) begin
            send_frame(bad_frame(), 1, n);
            idle(1);
        end
        idle(3);
        n_cmp++;
        if (bus.err_count !== 8'hFF || obs_q.size() != 0 || bus.key_active !== 1'b0) begin
            n_bad++;
            $display("FAIL errors_saturate: err_count=%h events=%0d active=%b, want FF, 0, 0",
                     bus.err_count, obs_q.size(), bus.key_active);
        end
    endtask

    task automatic test_overflow();
        int unsigned n0, n1;
        do_reset();
        bus.cmd_ready = 1'b0;
        send_frame(good_frame(8'h1A), 1, n0);
        tick();
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow} !== {1'b1, 8'h1A, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL ovf_press: got valid=%b key=%h press=%b ovf=%b, want 1 1A 1 0",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow);
        end
        idle(HOLD);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow} !== {1'b1, 8'h1A, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_release: got valid=%b key=%h press=%b ovf=%b, want 1 1A 0 1",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow);
        end
        send_frame(good_frame(8'h05), 1, n1);
        idle(6);
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow} !== {1'b1, 8'h05, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL ovf_latest: got valid=%b key=%h press=%b ovf=%b, want 1 05 1 1",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow);
        end
        bus.cmd_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.cmd_valid !== 1'b0 || bus.overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_consume: got valid=%b ovf=%b, want 0 1", bus.cmd_valid, bus.overflow);
        end
        idle(110);
    endtask

    // Release queued in the very cycle the pending press is consumed: slot reloads, no overflow.
    task automatic test_simultaneous();
        int unsigned n;
        do_reset();
        bus.cmd_ready = 1'b0;
        send_frame(good_frame(8'h1A), 1, n);
        idle(HOLD);
        bus.cmd_ready = 1'b1;
        tick();
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow} !== {1'b1, 8'h1A, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL simul_reload: got valid=%b key=%h press=%b ovf=%b, want 1 1A 0 0",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.overflow);
        end
        tick();
        n_cmp++;
        if (bus.cmd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL simul_clear: cmd_valid got %b, want 0", bus.cmd_valid);
        end
        idle(5);
    endtask

    task automatic test_reset_mid_hold();
        int unsigned n;
        bus.cmd_ready = 1'b0;
        send_frame(good_frame(8'h33), 1, n);
        idle(4);
        n_cmp++;
        if (bus.cmd_valid !== 1'b1 || bus.key_active !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_setup: got valid=%b active=%b, want 1 1", bus.cmd_valid, bus.key_active);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.key_active, bus.held_key, bus.err_count, bus.overflow} !== 28'h0) begin
            n_bad++;
            $display("FAIL rstmid_async: got valid=%b key=%h press=%b active=%b held=%h err=%h ovf=%b, want all zero",
                     bus.cmd_valid, bus.cmd_key, bus.cmd_press, bus.key_active, bus.held_key, bus.err_count, bus.overflow);
        end
        idle(3);
        rst = 1'b0;
        obs_q.delete();
        bus.cmd_ready = 1'b1;
        idle(200);
        n_cmp++;
        if (obs_q.size() != 0 || {bus.cmd_valid, bus.key_active, bus.held_key} !== 10'h0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: events=%0d valid=%b active=%b held=%h, want 0 0 0 00",
                     obs_q.size(), bus.cmd_valid, bus.key_active, bus.held_key);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.data_ready = 1'b0;
        bus.ir_data    = 32'h0;
        bus.cmd_ready  = 1'b0;
        test_reset();
        test_single_press();
        test_repeat();
        test_key_change();
        test_random();
        test_errors();
        test_overflow();
        test_simultaneous();
        test_reset_mid_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
